// File: rtl/wb_sram_ctrl.sv
// wb_sram_ctrl: Wishbone classic slave sequencing RW port 0 of sky130 32x512 OpenRAM banks.
// One transaction at a time: IDLE -> CMD -> (WAIT) -> ACK -> IDLE.
module wb_sram_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          NUM_BANKS = 2,
    parameter int          READ_WAIT = 1
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_adr_i,
    input  logic [31:0]            wbs_dat_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    output logic [NUM_BANKS-1:0]   sram_csb0_o,
    output logic                   sram_web0_o,
    output logic [3:0]             sram_wmask0_o,
    output logic [8:0]             sram_addr0_o,
    output logic [31:0]            sram_din0_o,
    input  logic [32*NUM_BANKS-1:0] sram_dout0_i
);
    localparam int LB = $clog2(NUM_BANKS);
    localparam int BW = (LB == 0) ? 1 : LB;
    localparam logic [1:0] IDLE = 2'd0, CMD = 2'd1, WAIT = 2'd2, ACK = 2'd3;

    logic [1:0]    state;
    logic [1:0]    cnt;
    logic          we_q;
    logic [BW-1:0] bank_q;
    logic [31:0]   dat_q;
    logic [31:0]   bank_w;
    logic          hit;
    logic          req;
    logic          access;
    logic          unused;

    assign hit    = ((wbs_adr_i ^ BASE_ADDR) >> (11 + LB)) == 32'd0;
    assign req    = wbs_cyc_i && wbs_stb_i && hit;
    assign bank_w = (wbs_adr_i >> 11) & 32'(NUM_BANKS - 1);
    assign access = !wbs_we_i || (wbs_sel_i != 4'd0);
    assign unused = ^{wbs_adr_i[1:0], bank_w};

    assign wbs_dat_o = (state == ACK && !we_q) ? dat_q : 32'd0;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state         <= IDLE;
            cnt           <= 2'd0;
            we_q          <= 1'b0;
            bank_q        <= '0;
            dat_q         <= 32'd0;
            wbs_ack_o     <= 1'b0;
            sram_csb0_o   <= '1;
            sram_web0_o   <= 1'b1;
            sram_wmask0_o <= 4'd0;
            sram_addr0_o  <= 9'd0;
            sram_din0_o   <= 32'd0;
        end else begin
            wbs_ack_o <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    state         <= CMD;
                    we_q          <= wbs_we_i;
                    bank_q        <= bank_w[BW-1:0];
                    sram_addr0_o  <= wbs_adr_i[10:2];
                    sram_din0_o   <= wbs_dat_i;
                    sram_wmask0_o <= wbs_sel_i;
                    sram_web0_o   <= !(wbs_we_i && access);
                    sram_csb0_o   <= access ? ~(NUM_BANKS'(1) << bank_w[BW-1:0]) : '1;
                end
                CMD: begin
                    sram_csb0_o   <= '1;
                    sram_web0_o   <= 1'b1;
                    sram_wmask0_o <= 4'd0;
                    cnt           <= 2'(READ_WAIT);
                    state         <= we_q ? ACK : WAIT;
                    wbs_ack_o     <= we_q && wbs_cyc_i;
                end
                WAIT: begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        // macro output has been stable for READ_WAIT cycles since its sample edge
                        dat_q     <= sram_dout0_i[32*bank_q +: 32];
                        state     <= ACK;
                        wbs_ack_o <= wbs_cyc_i;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_sram_ctrl.sv
// tb_wb_sram_ctrl: table vectors, hand-written abort/reset sequences and random traffic
// checked against a word-array reference of the 4 KB window.
module tb_wb_sram_ctrl;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'd0;
    logic [31:0] adr = 32'd0, dat_i = 32'd0;
    logic        ack;
    logic [31:0] dat_o;
    logic [1:0]  csb;
    logic        web;
    logic [3:0]  wmask;
    logic [8:0]  addr;
    logic [31:0] din;
    logic [63:0] dout;

    logic [31:0] sram_m [0:1][0:511];
    logic [31:0] sdout [0:1];
    logic        mem_clr = 1'b1;
    logic [31:0] ref_mem [0:1023];

    int checks = 0;
    int failures = 0;
    int dat_leak = 0;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        exp_ack;
        logic [31:0] exp_dat;
        logic [1:0]  exp_csb;
    } vec_t;
    vec_t vecs [16];

    wb_sram_ctrl dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .sram_csb0_o(csb), .sram_web0_o(web), .sram_wmask0_o(wmask),
        .sram_addr0_o(addr), .sram_din0_o(din), .sram_dout0_i(dout)
    );

    always #5 clk = ~clk;

    // behavioural macro pair: sample at the rising edge, read data appears after it
    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (mem_clr) begin
                for (int w = 0; w < 512; w++) sram_m[b][w] = 32'd0;
            end else if (!csb[b]) begin
                if (!web) begin
                    for (int i = 0; i < 4; i++)
                        if (wmask[i]) sram_m[b][addr][8*i +: 8] = din[8*i +: 8];
                end else begin
                    sdout[b] <= sram_m[b][addr];
                end
            end
        end
    end
    assign dout = {sdout[1], sdout[0]};

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, ".ack"}, 32'(ack), 32'd0);
        check({nm, ".dat_o"}, dat_o, 32'd0);
        check({nm, ".csb"}, 32'(csb), 32'd3);
        check({nm, ".web"}, 32'(web), 32'd1);
        check({nm, ".wmask"}, 32'(wmask), 32'd0);
        check({nm, ".addr"}, 32'(addr), 32'd0);
        check({nm, ".din"}, din, 32'd0);
    endtask

    // Called at a falling edge; drives one request and watches the bus until ack or budget.
    task automatic xfer(input logic we_v, input logic [31:0] adr_v, input logic [3:0] sel_v,
                        input logic [31:0] dat_v, input int budget,
                        output logic got_ack, output logic [31:0] got_dat, output int lat,
                        output int csb_n, output logic [1:0] csb_v, output int web_n,
                        output logic [3:0] mask_v, output logic [8:0] addr_v);
        cyc = 1'b1; stb = 1'b1; we = we_v; adr = adr_v; sel = sel_v; dat_i = dat_v;
        got_ack = 1'b0; got_dat = 32'd0; lat = 0; csb_n = 0; csb_v = 2'b11;
        web_n = 0; mask_v = 4'd0; addr_v = 9'd0;
        while (!got_ack && lat < budget) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (csb !== 2'b11) begin
                csb_n++; csb_v = csb; mask_v = wmask; addr_v = addr;
            end
            if (web === 1'b0) web_n++;
            if (ack === 1'b1) begin
                got_ack = 1'b1; got_dat = dat_o;
            end else if (dat_o !== 32'd0) dat_leak++;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (got_ack) begin
            @(posedge clk);
            @(negedge clk);
            check("ack_single_cycle", 32'(ack), 32'd0);
        end
    endtask

    task automatic run(input string nm, input logic we_v, input logic [31:0] adr_v,
                       input logic [3:0] sel_v, input logic [31:0] dat_v, input logic exp_ack,
                       input logic [31:0] exp_dat, input logic [1:0] exp_csb);
        logic a; logic [31:0] d; int lat, cn, wn; logic [1:0] cv; logic [3:0] mv; logic [8:0] av;
        int w;
        logic acc;
        acc = (exp_csb != 2'b11);
        xfer(we_v, adr_v, sel_v, dat_v, exp_ack ? 8 : 10, a, d, lat, cn, cv, wn, mv, av);
        check({nm, ".ack"}, 32'(a), 32'(exp_ack));
        if (exp_ack) check({nm, ".latency"}, 32'(lat), we_v ? 32'd2 : 32'd3);
        if (exp_ack && !we_v) check({nm, ".rdata"}, d, exp_dat);
        check({nm, ".csb_cycles"}, 32'(cn), 32'(acc));
        check({nm, ".web_cycles"}, 32'(wn), 32'(we_v && acc));
        if (acc) begin
            check({nm, ".csb"}, 32'(cv), 32'(exp_csb));
            check({nm, ".word"}, 32'(av), ((adr_v - BASE) / 4) % 512);
        end
        if (acc && we_v) check({nm, ".wmask"}, 32'(mv), 32'(sel_v));
        if (we_v && exp_ack) begin
            w = int'((adr_v - BASE) / 4);
            for (int i = 0; i < 4; i++)
                if (sel_v[i]) ref_mem[w][8*i +: 8] = dat_v[8*i +: 8];
        end
    endtask

    initial begin
        logic a; logic [31:0] d; int lat, cn, wn; logic [1:0] cv; logic [3:0] mv; logic [8:0] av;
        logic seen;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;

        vecs[0]  = '{1'b1, BASE + 32'h000, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0,        2'b10};
        vecs[1]  = '{1'b0, BASE + 32'h000, 4'hF, 32'h0,        1'b1, 32'hDEADBEEF, 2'b10};
        vecs[2]  = '{1'b1, BASE + 32'h7FC, 4'hF, 32'h11111111, 1'b1, 32'h0,        2'b10};
        vecs[3]  = '{1'b1, BASE + 32'h800, 4'hF, 32'h22222222, 1'b1, 32'h0,        2'b01};
        vecs[4]  = '{1'b0, BASE + 32'h7FC, 4'hF, 32'h0,        1'b1, 32'h11111111, 2'b10};
        vecs[5]  = '{1'b0, BASE + 32'h800, 4'hF, 32'h0,        1'b1, 32'h22222222, 2'b01};
        vecs[6]  = '{1'b1, BASE + 32'h004, 4'hF, 32'hAABBCCDD, 1'b1, 32'h0,        2'b10};
        vecs[7]  = '{1'b1, BASE + 32'h004, 4'h5, 32'h11223344, 1'b1, 32'h0,        2'b10};
        vecs[8]  = '{1'b0, BASE + 32'h004, 4'hF, 32'h0,        1'b1, 32'hAA22CC44, 2'b10};
        vecs[9]  = '{1'b1, BASE + 32'h004, 4'h0, 32'hFFFFFFFF, 1'b1, 32'h0,        2'b11};
        vecs[10] = '{1'b0, BASE + 32'h006, 4'hF, 32'h0,        1'b1, 32'hAA22CC44, 2'b10};
        vecs[11] = '{1'b0, BASE + 32'h1000, 4'hF, 32'h0,       1'b0, 32'h0,        2'b11};
        vecs[12] = '{1'b1, BASE + 32'h1000, 4'hF, 32'h12345678, 1'b0, 32'h0,       2'b11};
        vecs[13] = '{1'b1, BASE + 32'hFFC, 4'hF, 32'h5A5A5A5A, 1'b1, 32'h0,        2'b01};
        vecs[14] = '{1'b0, BASE + 32'hFFC, 4'hF, 32'h0,        1'b1, 32'h5A5A5A5A, 2'b01};
        vecs[15] = '{1'b0, BASE - 32'h4,   4'hF, 32'h0,        1'b0, 32'h0,        2'b11};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        mem_clr = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++)
            run($sformatf("vec%0d", i), vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat,
                vecs[i].exp_ack, vecs[i].exp_dat, vecs[i].exp_csb);

        // abort: cyc drops once the read is waiting on the macro
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h7FC; sel = 4'hF;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        cyc = 1'b0; stb = 1'b0;
        seen = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); seen |= (ack === 1'b1); end
        check("abort.no_ack", 32'(seen), 32'd0);
        run("abort.next_read", 1'b0, BASE + 32'h7FC, 4'hF, 32'h0, 1'b1, 32'h11111111, 2'b10);

        // reset while the read is waiting
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h804; sel = 4'hF; dat_i = 32'hFFFFFFFF;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run("midreset.read", 1'b0, BASE + 32'h800, 4'hF, 32'h0, 1'b1, 32'h22222222, 2'b01);

        for (int n = 0; n < 200; n++) begin
            logic        rwe;
            logic [3:0]  rsel;
            logic [31:0] radr, rdat, off;
            rwe  = 1'($urandom_range(0, 1));
            rsel = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            rdat = $urandom;
            if ($urandom_range(0, 6) == 0) begin
                radr = $urandom_range(0, 1) ? BASE + 32'h1000 + 32'($urandom_range(0, 4095)) * 4
                                            : BASE - 32'h4 - 32'($urandom_range(0, 255)) * 4;
                run($sformatf("rnd%0d", n), rwe, radr, rsel, rdat, 1'b0, 32'h0, 2'b11);
            end else begin
                off  = 32'($urandom_range(0, 15) + 256 * $urandom_range(0, 3)) * 4;
                radr = BASE + off + 32'($urandom_range(0, 3));
                run($sformatf("rnd%0d", n), rwe, radr, rsel, rdat, 1'b1, ref_mem[off / 4],
                    (rwe && rsel == 4'h0) ? 2'b11 : (off < 32'h800 ? 2'b10 : 2'b01));
            end
        end

        check("dat_o_zero_outside_ack", 32'(dat_leak), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_sram_ctrl.md
# wb_sram_ctrl

Wishbone classic slave that fronts the sky130 32x512 OpenRAM macros in the user project area. It decodes a configurable address window and sequences chip-select, write-enable, and byte-mask timing on the macros' RW port 0. It captures read data after the macro latency and generates `wbs_ack_o`. It sits between the management SoC Wishbone port of `user_project_wrapper` and the SRAM banks. Macro port 1 is unused by this block; the wrapper ties `csb1` high.

## Interface
Parameters:
- `BASE_ADDR`, 32'h3000_0000: window base; must be aligned to the window size.
- `NUM_BANKS`, 2: number of macros (power of two, 1..4).
- `READ_WAIT`, 1: cycles between the macro sample edge and the data-capture edge (1..3).

Ports:
- `wb_clk_i`  in  1  sole clock; drives the block and the macros.
- `wb_rst_ni`  in  1  asynchronous, active-low reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone classic cycle, strobe, and write enable.
- `wbs_sel_i`  in  4  byte lane selects.
- `wbs_adr_i`  in  32  byte address.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  single-cycle acknowledge.
- `wbs_dat_o`  out  32  read data; zero except during a read ACK.
- `sram_csb0_o`  out  NUM_BANKS  per-bank chip select, active low.
- `sram_web0_o`  out  1  write enable, active low, shared by all banks.
- `sram_wmask0_o`  out  4  byte write mask.
- `sram_addr0_o`  out  9  word address.
- `sram_din0_o`  out  32  write data to the macros.
- `sram_dout0_i`  in  32*NUM_BANKS  read data; bank b is on slice [32b+31:32b].

## Operation
- **Window.** Window size is NUM_BANKS*2 KB.
  - Hit: `wbs_adr_i[31:11+log2(NUM_BANKS)]` equals the same bits of BASE_ADDR.
  - Word index: `adr[10:2]`. Bank: `adr[11 +: log2(NUM_BANKS)]`. `adr[1:0]` is ignored.
- **Misses.** A miss produces no response (no ack, no macro access). Other slaves handle it.
- **FSM states:** IDLE, CMD, WAIT, ACK.
- **IDLE.**
  - On `cyc&stb&hit`, latch address, bank, we, sel, and data.
  - Load the macro output registers. `csb0[bank]` goes low only if this is a read, or a write with `sel!=0`.
  - Next state: CMD.
- **CMD.** Exactly one cycle with the macro inputs stable; the macro samples at the closing edge.
  - Write: next state ACK.
  - Read: load the wait counter with READ_WAIT; next state WAIT.
  - On exit, `csb0` returns to all ones and `web0` to 1.
- **WAIT.**
  - Decrement the counter each cycle.
  - On the edge where the counter reaches 0, capture `sram_dout0_i[bank]` into the data register; next state ACK.
- **ACK.**
  - `wbs_ack_o = wbs_cyc_i`, so the ack is suppressed if the master has aborted.
  - `wbs_dat_o` = captured data for a read, 0 for a write.
  - Next state is always IDLE, so there is at least one IDLE cycle between transactions.
- **Write mask.**
  - `sram_web0_o = 0` in CMD for writes, otherwise 1.
  - `sram_wmask0_o = wbs_sel_i` latched; 0 outside CMD.
- **Empty write.** A write with `sel==0` is acked with no macro access.
- **Abort.** If `cyc` drops during CMD or WAIT, the macro operation still completes (a write already issued lands). The FSM runs to ACK with ack suppressed, then returns to IDLE.
- **Master behaviour.** A master holding `stb` after the ack starts a new transaction from IDLE; the block does no pipelining.

## Timing
- **Reset values (asynchronous, on `wb_rst_ni=0`):**
  - state IDLE
  - `sram_csb0_o` all ones, `sram_web0_o=1`
  - `sram_wmask0_o=0`, `sram_addr0_o=0`, `sram_din0_o=0`
  - `wbs_ack_o=0`, `wbs_dat_o=0`, data register 0
  - A macro operation in flight at reset is undefined.
- **Write latency.** Request sampled at edge 0. CMD runs cycle 0→1. Ack is high in cycle 1→2, i.e. 2 edges after the request.
- **Read latency.** 2+READ_WAIT edges; with the default READ_WAIT=1, ack arrives on edge 3.
- **Output sourcing.** All macro-facing outputs and `wbs_ack_o` are driven from flops. `wbs_dat_o` is a flop gated by the ACK state.
- **Wrap.** None. Word 511 of bank b is adjacent to word 0 of bank b+1; the top word of the top bank is the last address in the window.

## Test plan
- **Basic write/read.** Write 32'hDEADBEEF, sel 4'hF, to BASE+0x000, then read it back.
  - Write: ack on edge 2; `csb0=2'b10` and `web0=0` for exactly one cycle.
  - Read: ack on edge 3 with `wbs_dat_o=32'hDEADBEEF`.
- **Bank boundary.** Write 32'h1111_1111 to BASE+0x7FC and 32'h2222_2222 to BASE+0x800.
  - First write: bank0, addr 511. Second write: bank1, addr 0.
  - Read-backs return the respective values.
- **Byte mask.** Write with sel 4'b0101.
  - Required: `wmask0=4'b0101` in CMD.
  - A write with sel 4'h0 is acked with `csb0` staying all ones.
- **Window miss.** Access BASE+0x1000 with NUM_BANKS=2.
  - Required: no ack, `csb0` stays all ones for 10 cycles, FSM stays IDLE.
- **Abort.** Drop `cyc` during WAIT of a read.
  - Required: `wbs_ack_o` stays 0, the FSM is back in IDLE 2 cycles later, and the next read acks normally.
- **Reset mid-read.** Pulse `wb_rst_ni` low during WAIT.
  - Required: all outputs take reset values immediately (asynchronously); after release, a fresh read completes with a 3-cycle latency.
